// File: rtl/nibble_to_byte_bram_fifo.sv
// nibble_to_byte_bram_fifo: nibble-in, byte-out FIFO controller around a mixed-width
// dual-port block RAM (port A 4-bit write, port B 8-bit read, 1-cycle read latency).
module nibble_to_byte_bram_fifo #(
    parameter int AW_A = 12,
    parameter int AW_B = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [3:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW_B:0]   byte_count,
    output logic            nib_pending,
    output logic            ram_ena,
    output logic            ram_wea,
    output logic [AW_A-1:0] ram_addra,
    output logic [3:0]      ram_dia,
    output logic            ram_enb,
    output logic [AW_B-1:0] ram_addrb,
    input  logic [7:0]      ram_dob
);
    logic [AW_A:0] wr_ptr, used, wr_ptr_n;
    logic [AW_B:0] rd_ptr, avail, rd_ptr_n, bc_n;
    logic [1:0]    cnt, lvl, occ, cnt_n;
    logic [7:0]    buf0, buf1, buf0_n, buf1_n;
    logic          inflight, clr, full, wr, issue, pop;
    assign clr      = reset | flush;
    assign used     = wr_ptr - {rd_ptr, 1'b0};
    assign full     = used[AW_A];
    assign in_ready = !full && !clr;
    assign wr       = in_valid && in_ready;
    assign avail    = wr_ptr[AW_A:1] - rd_ptr;
    assign out_valid = cnt != 2'd0;
    assign out_data  = buf0;
    assign pop       = out_valid && out_ready;
    assign nib_pending = wr_ptr[0];
    // occupancy after this cycle's pop lets a read issue every cycle while draining
    assign occ   = cnt + {1'b0, inflight} - {1'b0, pop};
    assign issue = !clr && avail != '0 && occ < 2'd2;
    assign ram_ena   = wr;
    assign ram_wea   = wr;
    assign ram_addra = wr ? wr_ptr[AW_A-1:0] : '0;
    assign ram_dia   = wr ? in_data : 4'd0;
    assign ram_enb   = issue;
    assign ram_addrb = issue ? rd_ptr[AW_B-1:0] : '0;
    always_comb begin
        lvl      = cnt - {1'b0, pop};
        buf0_n   = (inflight && lvl == 2'd0) ? ram_dob : pop ? buf1 : buf0;
        buf1_n   = (inflight && lvl == 2'd1) ? ram_dob : buf1;
        cnt_n    = lvl + {1'b0, inflight};
        wr_ptr_n = wr_ptr + (AW_A+1)'(wr);
        rd_ptr_n = rd_ptr + (AW_B+1)'(issue);
        bc_n     = (wr_ptr_n[AW_A:1] - rd_ptr_n) + (AW_B+1)'(issue) + (AW_B+1)'(cnt_n);
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= 2'd0;
            inflight   <= 1'b0;
            buf0       <= 8'd0;
            buf1       <= 8'd0;
            byte_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            cnt        <= cnt_n;
            inflight   <= issue;
            buf0       <= buf0_n;
            buf1       <= buf1_n;
            byte_count <= bc_n;
        end
    end
endmodule

// File: tb/tb_nibble_to_byte_bram_fifo.sv
// tb_nibble_to_byte_bram_fifo: directed and random checks of the nibble-to-byte FIFO
// with a behavioural mixed-width RAM and a byte-order scoreboard.
module tb_nibble_to_byte_bram_fifo;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready = 1'b0;
    logic [11:0] byte_count;
    logic        nib_pending, ram_ena, ram_wea, ram_enb;
    logic [11:0] ram_addra;
    logic [3:0]  ram_dia;
    logic [10:0] ram_addrb;
    logic [7:0]  ram_dob;
    logic [3:0]  mem [4096];
    logic [7:0]  bq [$];
    logic [3:0]  lo;
    logic [7:0]  last_pop = 8'd0;
    logic        have = 1'b0;
    int n_chk = 0, n_fail = 0, pops = 0, full_viol = 0, coll = 0, tb_wr = 0, tb_rd = 0;
    int p0, n, acc;

    nibble_to_byte_bram_fifo dut (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .byte_count(byte_count), .nib_pending(nib_pending), .ram_ena(ram_ena), .ram_wea(ram_wea),
        .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
        .ram_dob(ram_dob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mixed-width RAM: read-first, one cycle latency, flags same-byte A/B access
    always @(posedge clk) begin
        if (ram_ena && ram_wea && ram_enb && ram_addra[11:1] == ram_addrb) coll++;
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= {mem[{ram_addrb, 1'b1}], mem[{ram_addrb, 1'b0}]};
    end

    always @(negedge clk) begin
        if (reset || flush) begin
            bq.delete();
            have = 1'b0;
            tb_wr = 0;
            tb_rd = 0;
        end else begin
            if (in_ready && tb_wr - 2 * tb_rd >= 4096) full_viol++;
            if (ram_enb) tb_rd++;
            if (out_valid && out_ready) begin
                pops++;
                last_pop = out_data;
                if (bq.size() == 0) chk("pop_when_empty", 32'(out_data), 32'hffff_ffff);
                else chk("pop_order", 32'(out_data), 32'(bq.pop_front()));
            end
            if (in_valid && in_ready) begin
                tb_wr++;
                if (have) bq.push_back({in_data, lo});
                else lo = in_data;
                have = !have;
            end
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_byte_count", 32'(byte_count), 0);
        chk("rst_nib_pending", 32'(nib_pending), 0);
        chk("rst_ram_en", {30'd0, ram_ena, ram_enb}, 0);
        chk("rst_out_data", 32'(out_data), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // latency of the first byte
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'h1; tick();
        in_data = 4'h2; tick();
        in_valid = 1'b0;
        chk("lat_k", 32'(out_valid), 0);
        tick();
        chk("lat_k1", 32'(out_valid), 0);
        tick();
        chk("lat_k2_valid", 32'(out_valid), 1);
        chk("lat_k2_data", 32'(out_data), 32'h21);
        chk("lat_k2_count", 32'(byte_count), 1);
        tick();
        chk("lat_pop_count", 32'(byte_count), 0);
        chk("lat_pop_valid", 32'(out_valid), 0);

        // odd nibble stays hidden
        p0 = pops;
        in_valid = 1'b1;
        in_data = 4'hA; tick();
        in_data = 4'hB; tick();
        in_data = 4'hC; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("odd_pops", pops - p0, 1);
        chk("odd_byte", 32'(last_pop), 32'hBA);
        chk("odd_pending", 32'(nib_pending), 1);
        chk("odd_count", 32'(byte_count), 0);
        chk("odd_valid", 32'(out_valid), 0);
        in_valid = 1'b1; in_data = 4'hD; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("odd_pops2", pops - p0, 2);
        chk("odd_byte2", 32'(last_pop), 32'hDC);
        chk("odd_pending2", 32'(nib_pending), 0);

        // streaming: one byte per two cycles
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin in_data = 4'(c); tick(); end
        p0 = pops;
        for (int c = 0; c < 20; c++) begin in_data = 4'(c + 3); tick(); end
        chk("stream_rate", pops - p0, 10);
        in_valid = 1'b0;
        repeat (5) tick();
        chk("stream_drained", 32'(byte_count), 0);

        // fill to full with the consumer stalled
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 5000 && in_ready; c++) begin
            in_valid = 1'b1; in_data = 4'(n); tick(); n++;
        end
        in_valid = 1'b0;
        chk("fill_accepts", n, 4100);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_count", 32'(byte_count), 2050);
        chk("fill_pending", 32'(nib_pending), 0);
        chk("fill_head", 32'(out_data), 32'h10);
        p0 = pops;
        out_ready = 1'b1;
        for (int c = 0; c < 6000 && byte_count != 0; c++) tick();
        tick();
        chk("drain_count", 32'(byte_count), 0);
        chk("drain_pops", pops - p0, 2050);
        chk("drain_last", 32'(last_pop), 32'h32);

        // flush with a read in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h7; tick();
        in_data = 4'h8; tick();
        in_data = 4'h9; tick();
        in_data = 4'hA; tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !ram_enb; c++) tick();
        chk("flush_issue_seen", 32'(ram_enb), 1);
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_count", 32'(byte_count), 0);
        chk("flush_pending", 32'(nib_pending), 0);
        p0 = pops;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'h5;
        #1;
        chk("flush_addr0", {19'd0, ram_ena, ram_addra}, 32'h1000);
        tick();
        in_data = 4'h6; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("flush_pops", pops - p0, 1);
        chk("flush_byte", 32'(last_pop), 32'h65);

        // random traffic across pointer wrap
        acc = 0;
        p0 = pops;
        for (int c = 0; c < 60000 && acc < 20000; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = 4'($urandom);
            out_ready = acc < 10000 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
            #1;
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6000 && byte_count != 0; c++) tick();
        tick();
        chk("rand_accepts", acc, 20000);
        chk("rand_pops", pops - p0, 10000);
        chk("rand_sb_empty", bq.size(), 0);
        chk("rand_count", 32'(byte_count), 0);
        chk("full_violations", full_viol, 0);
        chk("ram_collisions", coll, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
